uart_tx: RTL and testbench



---
 rtl/uart_tx_pkg.sv | 16 +
 rtl/uart_tx_fifo.sv | 48 ++++
 rtl/uart_tx.sv | 145 ++++++++++++++
 tb/tb_uart_tx.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// Shared UART constants and the transmit FSM state type.
package uart_tx_pkg;

    localparam int NUM_DATA_BITS = 8;
    localparam int CLK_FRQ       = 50_000_000;
    localparam int BAUD_RATE_TX  = 115_200;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO for the UART transmitter; an extra pointer bit separates full from empty.
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk50,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             push_ok;
    logic             pop_ok;

    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_ff @(posedge clk50 or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage is not reset; the pointers alone define the contents.
    always_ff @(posedge clk50) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= din;
    end

    assign dout  = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count = wr_ptr - rd_ptr;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: 8 data bits LSB first, even parity, 1 stop bit, FIFO fed, CTS gated at launch.
module uart_tx #(
    parameter int CLK_FRQ    = uart_tx_pkg::CLK_FRQ,
    parameter int BAUD_RATE  = uart_tx_pkg::BAUD_RATE_TX,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                                   clk50,
    input  logic                                   reset,
    input  logic                                   enable,
    input  logic [uart_tx_pkg::NUM_DATA_BITS-1:0]  tx_data,
    input  logic                                   tx_valid,
    output logic                                   tx_ready,
    input  logic                                   uart_cts,
    output logic                                   uart_txd,
    output logic                                   busy,
    output logic                                   done,
    output logic [$clog2(FIFO_DEPTH):0]            fifo_count
);

    import uart_tx_pkg::*;

    localparam int DIV = CLK_FRQ / BAUD_RATE;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [2:0]    BIT_LAST = 3'(NUM_DATA_BITS - 1);

    tx_state_t               state, state_next;
    logic [CW-1:0]           cnt, cnt_next;
    logic [2:0]              bit_idx, bit_idx_next;
    logic [NUM_DATA_BITS-1:0] shift, shift_next;
    logic                    parity, parity_next;
    logic                    txd_next;
    logic                    cts_meta, cts_s;
    logic                    fifo_full, fifo_empty;
    logic [NUM_DATA_BITS-1:0] fifo_dout;
    logic                    push, pop, launch, bit_end;

    assign tx_ready = !fifo_full;
    assign push     = tx_valid && tx_ready;
    assign launch   = !fifo_empty && enable && cts_s;
    assign bit_end  = (cnt == CNT_LAST);
    assign busy     = (state != IDLE);
    assign done     = (state == STOP) && bit_end;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (NUM_DATA_BITS)
    ) u_fifo (
        .clk50 (clk50),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (tx_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        state_next   = state;
        cnt_next     = bit_end ? '0 : cnt + 1'b1;
        bit_idx_next = bit_idx;
        shift_next   = shift;
        parity_next  = parity;
        pop          = 1'b0;
        txd_next     = 1'b1;

        case (state)
            IDLE: begin
                cnt_next = '0;
                if (launch) begin
                    pop         = 1'b1;
                    shift_next  = fifo_dout;
                    parity_next = ^fifo_dout;
                    state_next  = START;
                end
            end
            START: begin
                if (bit_end) begin
                    bit_idx_next = '0;
                    state_next   = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_idx == BIT_LAST) begin
                        state_next = PARITY;
                    end else begin
                        bit_idx_next = bit_idx + 1'b1;
                        shift_next   = {1'b0, shift[NUM_DATA_BITS-1:1]};
                    end
                end
            end
            PARITY: begin
                if (bit_end) state_next = STOP;
            end
            STOP: begin
                if (bit_end) begin
                    // Back-to-back launch from the final stop clock avoids an idle gap.
                    if (launch) begin
                        pop         = 1'b1;
                        shift_next  = fifo_dout;
                        parity_next = ^fifo_dout;
                        state_next  = START;
                    end else begin
                        state_next  = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        // Line level is derived from next-state so uart_txd stays a plain flop.
        case (state_next)
            START:   txd_next = 1'b0;
            DATA:    txd_next = shift_next[0];
            PARITY:  txd_next = parity_next;
            default: txd_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk50 or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            parity   <= 1'b0;
            uart_txd <= 1'b1;
            cts_meta <= 1'b0;
            cts_s    <= 1'b0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            bit_idx  <= bit_idx_next;
            shift    <= shift_next;
            parity   <= parity_next;
            uart_txd <= txd_next;
            cts_meta <= uart_cts;
            cts_s    <= cts_meta;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed self-checking bench for uart_tx at DIV = 8, FIFO depth 4.
module tb_uart_tx;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       cts;
    logic       txd;
    logic       busy;
    logic       done;
    logic [2:0] fifo_count;

    int checks   = 0;
    int failures = 0;

    uart_tx #(
        .CLK_FRQ    (800),
        .BAUD_RATE  (100),
        .FIFO_DEPTH (4)
    ) dut (
        .clk50      (clk),
        .reset      (rst_n),
        .enable     (enable),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .uart_cts   (cts),
        .uart_txd   (txd),
        .busy       (busy),
        .done       (done),
        .fifo_count (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [10:0] frame_of(input logic [7:0] b);
        return {1'b1, ^b, b, 1'b0};
    endfunction

    task automatic push_byte(input logic [7:0] b);
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = b;
        @(posedge clk);
        #1 tx_valid = 1'b0;
    endtask

    // Waits up to max_wait extra negedges for the start bit, then checks all 88 clocks.
    task automatic check_frame(input logic [10:0] exp, input string tag, input int max_wait);
        int w;
        w = 0;
        @(negedge clk);
        while (txd !== 1'b0 && w < max_wait) begin
            @(negedge clk);
            w++;
        end
        for (int c = 0; c < 88; c++) begin
            if (c > 0) @(negedge clk);
            check($sformatf("%s_txd_c%0d", tag, c), 32'(txd), 32'(exp[c/8]));
            check($sformatf("%s_done_c%0d", tag, c), 32'(done), 32'(c == 87));
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic saw_low;
        bit   accepted;
        bit   found;

        rst_n    = 1'b1;
        enable   = 1'b1;
        tx_data  = 8'h00;
        tx_valid = 1'b0;
        cts      = 1'b1;

        // Reset values
        #2 rst_n = 1'b0;
        #1;
        check("rst_txd",   32'(txd), 32'd1);
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_done",  32'(done), 32'd0);
        check("rst_ready", 32'(tx_ready), 32'd1);
        check("rst_count", 32'(fifo_count), 32'd0);
        wait_cycles(2);
        rst_n = 1'b1;
        wait_cycles(4);

        // 0x55, first-byte latency: txd still high right after the push edge
        push_byte(8'h55);
        @(negedge clk);
        check("lat_txd_n", 32'(txd), 32'd1);
        check("lat_cnt_n", 32'(fifo_count), 32'd1);
        check_frame(11'b1_0_0101_0101_0, "f55", 0);
        @(negedge clk);
        check("f55_idle_txd",  32'(txd), 32'd1);
        check("f55_idle_busy", 32'(busy), 32'd0);

        // 0xA7: data 1,1,1,0,0,1,0,1 and parity 1
        push_byte(8'hA7);
        check_frame(11'b1_1_1010_0111_0, "fa7", 1);
        @(negedge clk);
        check("fa7_idle_busy", 32'(busy), 32'd0);

        // Fill FIFO with cts low, 5th byte held off by the handshake
        cts = 1'b0;
        wait_cycles(3);
        push_byte(8'h11);
        push_byte(8'h22);
        push_byte(8'h33);
        push_byte(8'h44);
        @(negedge clk);
        check("full_ready", 32'(tx_ready), 32'd0);
        check("full_count", 32'(fifo_count), 32'd4);
        check("full_txd",   32'(txd), 32'd1);
        tx_data  = 8'h5A;
        tx_valid = 1'b1;
        wait_cycles(5);
        check("full_hold_count", 32'(fifo_count), 32'd4);
        check("full_hold_busy",  32'(busy), 32'd0);
        cts = 1'b1;
        accepted = 1'b0;
        fork
            begin
                check_frame(frame_of(8'h11), "b2b1", 4);
                check_frame(frame_of(8'h22), "b2b2", 0);
                check_frame(frame_of(8'h33), "b2b3", 0);
                check_frame(frame_of(8'h44), "b2b4", 0);
                check_frame(frame_of(8'h5A), "b2b5", 0);
            end
            begin
                for (int t = 0; t < 400; t++) begin
                    @(negedge clk);
                    if (tx_ready) begin
                        @(posedge clk);
                        #1 tx_valid = 1'b0;
                        accepted = 1'b1;
                        break;
                    end
                end
                tx_valid = 1'b0;
                check("fifth_accepted", 32'(accepted), 32'd1);
            end
        join
        @(negedge clk);
        check("b2b_idle_busy",  32'(busy), 32'd0);
        check("b2b_idle_count", 32'(fifo_count), 32'd0);

        // CTS dropped mid-data with 2 queued: frame completes, then line stays high
        cts = 1'b0;
        wait_cycles(3);
        push_byte(8'h3C);
        push_byte(8'hC3);
        push_byte(8'h81);
        cts = 1'b1;
        fork
            check_frame(frame_of(8'h3C), "cdrop", 4);
            begin
                found = 1'b0;
                for (int t = 0; t < 10; t++) begin
                    @(negedge clk);
                    if (txd === 1'b0) begin
                        found = 1'b1;
                        break;
                    end
                end
                check("cdrop_start_seen", 32'(found), 32'd1);
                wait_cycles(40);
                cts = 1'b0;
            end
        join
        saw_low = 1'b0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (txd !== 1'b1) saw_low = 1'b1;
        end
        check("cdrop_quiet", 32'(saw_low), 32'd0);
        check("cdrop_count", 32'(fifo_count), 32'd2);
        check("cdrop_busy",  32'(busy), 32'd0);
        cts = 1'b1;
        @(negedge clk);
        check("cts_lat1", 32'(txd), 32'd1);
        @(negedge clk);
        check("cts_lat2", 32'(txd), 32'd1);
        check_frame(frame_of(8'hC3), "cts_c3", 0);
        check_frame(frame_of(8'h81), "cts_81", 0);
        @(negedge clk);
        check("cts_idle_busy", 32'(busy), 32'd0);

        // Reset during DATA of 0xFF with 3 bytes queued
        cts = 1'b0;
        wait_cycles(3);
        push_byte(8'hFF);
        push_byte(8'h01);
        push_byte(8'h02);
        push_byte(8'h03);
        cts = 1'b1;
        found = 1'b0;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            if (txd === 1'b0) begin
                found = 1'b1;
                break;
            end
        end
        check("rmid_start_seen", 32'(found), 32'd1);
        wait_cycles(28);
        check("rmid_busy_pre",  32'(busy), 32'd1);
        check("rmid_count_pre", 32'(fifo_count), 32'd3);
        rst_n = 1'b0;
        #1;
        check("rmid_txd",   32'(txd), 32'd1);
        check("rmid_count", 32'(fifo_count), 32'd0);
        check("rmid_busy",  32'(busy), 32'd0);
        check("rmid_ready", 32'(tx_ready), 32'd1);
        wait_cycles(2);
        rst_n = 1'b1;
        saw_low = 1'b0;
        for (int t = 0; t < 120; t++) begin
            @(negedge clk);
            if (txd !== 1'b1) saw_low = 1'b1;
        end
        check("rmid_quiet", 32'(saw_low), 32'd0);
        check("rmid_count_post", 32'(fifo_count), 32'd0);

        // Simultaneous push/pop at count 2 across pointer wrap-around
        cts = 1'b0;
        wait_cycles(3);
        push_byte(8'hA1);
        push_byte(8'hA2);
        push_byte(8'hA3);
        @(negedge clk);
        check("pp_count_init", 32'(fifo_count), 32'd3);
        cts = 1'b1;
        fork
            begin
                check_frame(frame_of(8'hA1), "pp1", 4);
                check_frame(frame_of(8'hA2), "pp2", 0);
                check_frame(frame_of(8'hA3), "pp3", 0);
                check_frame(frame_of(8'hA4), "pp4", 0);
                check_frame(frame_of(8'hA5), "pp5", 0);
                check_frame(frame_of(8'hA6), "pp6", 0);
            end
            begin
                for (int k = 0; k < 3; k++) begin
                    found = 1'b0;
                    for (int t = 0; t < 300; t++) begin
                        @(negedge clk);
                        if (done === 1'b1) begin
                            found = 1'b1;
                            break;
                        end
                    end
                    check($sformatf("pp_done_seen%0d", k), 32'(found), 32'd1);
                    check($sformatf("pp_count_pre%0d", k), 32'(fifo_count), 32'd2);
                    tx_data  = 8'hA4 + 8'(k);
                    tx_valid = 1'b1;
                    @(posedge clk);
                    #1 tx_valid = 1'b0;
                    @(negedge clk);
                    check($sformatf("pp_count_post%0d", k), 32'(fifo_count), 32'd2);
                end
            end
        join
        @(negedge clk);
        check("pp_idle_busy",  32'(busy), 32'd0);
        check("pp_idle_count", 32'(fifo_count), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
